// File: rtl/ahb_apb_rw_bridge.sv
// AHB-Lite slave to APB master bridge: each AHB transfer is split into
// sequential APB beats, with read lanes packed and write lanes unpacked.
module ahb_apb_rw_bridge #(
  parameter int AHB_AW = 32,
  parameter int APB_AW = 32,
  parameter int AHB_DW = 32,
  parameter int APB_DW = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [AHB_AW-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic              HWRITE,
  input  logic [AHB_DW-1:0] HWDATA,
  output logic [AHB_DW-1:0] HRDATA,
  output logic              HREADY,
  output logic              HRESP,
  output logic [APB_AW-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [APB_DW-1:0] PWDATA,
  input  logic [APB_DW-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int RATIO   = AHB_DW / APB_DW;
  localparam int BB      = APB_DW / 8;
  localparam int ABYTES  = AHB_DW / 8;
  localparam int BCW     = $clog2(RATIO) + 1;
  localparam int LANE_SH = $clog2(BB);
  localparam logic [2:0] MAXSZ = 3'($clog2(ABYTES));

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e            state_q, state_d;
  logic [AHB_AW-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic              write_q, write_d;
  logic [AHB_DW-1:0] wdata_q, wdata_d;
  logic [AHB_DW-1:0] rdata_q, rdata_d;
  logic [BCW-1:0]    beat_q, beat_d;

  logic              accept;
  logic              illegal;
  logic [AHB_AW-1:0] amask;
  logic [31:0]       lane;
  logic [31:0]       shift;
  logic              last;
  logic              unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      beat_q  <= beat_d;
    end
  end

  assign HREADY  = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign HRESP   = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign PSEL    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign PENABLE = (state_q == S_ACCESS);
  assign PWRITE  = write_q;
  assign HRDATA  = rdata_q;

  assign accept  = HREADY && HSEL && HTRANS[1];
  assign amask   = (AHB_AW'(1) << HSIZE) - AHB_AW'(1);
  assign illegal = (HSIZE > MAXSZ) || ((HADDR & amask) != '0);

  // Lane of the current beat within the AHB data bus.
  assign lane  = (32'(addr_q & AHB_AW'(ABYTES - 1)) >> LANE_SH)
               + 32'(beat_q);
  assign shift = lane * 32'(APB_DW);
  assign last  = ((32'(beat_q) + 32'd1) * 32'(APB_DW))
               >= (32'd8 << size_q);

  assign PADDR  = APB_AW'(addr_q)
                + APB_AW'(32'(beat_q) * 32'(BB));
  assign PWDATA = APB_DW'(wdata_q >> shift);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    beat_d  = beat_q;
    unique case (state_q)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          addr_d  = HADDR;
          size_d  = HSIZE;
          write_d = HWRITE;
          beat_d  = '0;
          if (illegal) begin
            state_d = S_ERR1;
          end else if (HWRITE) begin
            state_d = S_WDATA;
          end else begin
            rdata_d = '0;
            state_d = S_SETUP;
          end
        end
      end
      S_WDATA: begin
        wdata_d = HWDATA;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR) begin
            beat_d  = '0;
            state_d = S_ERR1;
          end else begin
            if (!write_q) begin
              rdata_d = rdata_q | (AHB_DW'(PRDATA) << shift);
            end
            if (last) begin
              beat_d  = '0;
              state_d = S_IDLE;
            end else begin
              beat_d  = beat_q + BCW'(1);
              state_d = S_SETUP;
            end
          end
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
